tx_msg_streamer: RTL and testbench

Parametrised, writable message store with a built-in byte sequencer for the UART transmitter path. Holds 2^ADDR_W words, and on a start pulse streams a selected message (base address plus length) to the transmitter over a valid/ready handshake. The block owns all message fetch and pacing; the transmitter only consumes bytes.

---
 rtl/tx_msg_streamer.sv | 117 +++++++++++
 tb/tb_tx_msg_streamer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tx_msg_streamer.sv
// rtl/tx_msg_streamer.sv - writable message store that streams one message per start over valid/ready
// Optional build macro TX_MSG_CRLF_EN appends 0x0D 0x0A after every message.
module tx_msg_streamer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] msg_base,
  input  logic [ADDR_W:0]   msg_len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   rem;
`ifdef TX_MSG_CRLF_EN
  // 0: message words, 1: CR byte, 2: LF byte
  logic [1:0]        tail;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      ptr      <= '0;
      rem      <= '0;
`ifdef TX_MSG_CRLF_EN
      tail     <= 2'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr <= msg_base;
            rem <= msg_len;
`ifdef TX_MSG_CRLF_EN
            tail  <= (msg_len == '0) ? 2'd1 : 2'd0;
            state <= FETCH;
            busy  <= 1'b1;
`else
            if (msg_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
              busy  <= 1'b1;
            end
`endif
          end
        end
        FETCH: begin
          state    <= SEND;
          tx_valid <= 1'b1;
`ifdef TX_MSG_CRLF_EN
          if (tail == 2'd1)      tx_data <= DATA_W'(8'h0D);
          else if (tail == 2'd2) tx_data <= DATA_W'(8'h0A);
          else                   tx_data <= mem[ptr];
`else
          tx_data  <= mem[ptr];
`endif
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
`ifdef TX_MSG_CRLF_EN
            if (tail == 2'd2) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (tail == 2'd1 || rem == (ADDR_W+1)'(1)) begin
              tail  <= tail + 2'd1;
              state <= FETCH;
            end else begin
              ptr   <= ptr + ADDR_W'(1);
              rem   <= rem - (ADDR_W+1)'(1);
              state <= FETCH;
            end
`else
            if (rem == (ADDR_W+1)'(1)) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ptr   <= ptr + ADDR_W'(1);
              rem   <= rem - (ADDR_W+1)'(1);
              state <= FETCH;
            end
`endif
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tx_msg_streamer.sv
// tb/tb_tx_msg_streamer.sv - directed table-driven bench for tx_msg_streamer
module tb_tx_msg_streamer;
  logic       clk = 1'b0;
  logic       rst, start, tx_ready, wr_en;
  logic [4:0] msg_base, wr_addr;
  logic [5:0] msg_len;
  logic [7:0] wr_data, tx_data;
  logic       busy, done, tx_valid;
  int         n_cmp = 0;
  int         n_fail = 0;

  tx_msg_streamer #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_base(msg_base), .msg_len(msg_len),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  base;
    logic [5:0]  len;
    logic [63:0] exp;   // first byte in bits 63:56
    int          sidx;
    int          scyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_stream(input logic [4:0] b, input logic [5:0] l, input logic [63:0] exp,
                            input int sidx, input int scyc, input bit inj, input logic [7:0] inj_d);
    int nb, scnt, busy_cnt, done_k, exp_n;
    logic [7:0] got [$];
    logic [7:0] last, eb;
    bit held_ok, was_stall;
    nb = 0; scnt = 0; busy_cnt = 0; done_k = 0; held_ok = 1; was_stall = 0; last = '0;
    @(negedge clk);
    start = 1'b1; msg_base = b; msg_len = l; tx_ready = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (inj && k == 1) begin
        start = 1'b1; msg_base = b + 5'd1; msg_len = 6'd1;
        wr_en = 1'b1; wr_addr = b; wr_data = inj_d;
      end
      if (k == 2) wr_en = 1'b0;
      if (was_stall && !(tx_valid && tx_data == last)) held_ok = 0;
      if (busy) busy_cnt++;
      if (done) begin
        done_k = k;
        break;
      end
      tx_ready = !(nb == sidx && scnt < scyc);
      was_stall = tx_valid && !tx_ready;
      if (was_stall) scnt++;
      last = tx_data;
      if (tx_valid && tx_ready) begin
        got.push_back(tx_data);
        nb++;
      end
    end
    wr_en = 1'b0;
`ifdef TX_MSG_CRLF_EN
    exp_n = int'(l) + 2;
`else
    exp_n = int'(l);
`endif
    check("done_seen", int'(done_k != 0), 1);
    check("nbytes", got.size(), exp_n);
    for (int j = 0; j < exp_n && j < got.size(); j++) begin
      if (j < int'(l)) eb = exp[63 - 8*j -: 8];
      else             eb = (j == int'(l)) ? 8'h0D : 8'h0A;
      check($sformatf("byte%0d", j), got[j], eb);
    end
    check("done_latency", done_k, (exp_n == 0) ? 1 : 2*exp_n + 1 + scyc);
    check("busy_cycles", busy_cnt, (exp_n == 0) ? 0 : 2*exp_n + scyc);
    if (scyc > 0) check("stall_hold", int'(held_ok), 1);
    tx_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", int'(busy), 0);
    start = 1'b0;
  endtask

  initial begin
    int nb;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0; wr_en = 1'b0;
    msg_base = '0; msg_len = '0; wr_addr = '0; wr_data = '0;

    vecs[0] = '{5'd0,  6'd6, 64'h4B49_5348_414E_0000, -1, 0};
    vecs[1] = '{5'd0,  6'd6, 64'h4B49_5348_414E_0000,  2, 5};
    vecs[2] = '{5'd31, 6'd3, 64'hAA4B_4900_0000_0000, -1, 0};
    vecs[3] = '{5'd2,  6'd1, 64'h5300_0000_0000_0000, -1, 0};
    vecs[4] = '{5'd0,  6'd0, 64'h0,                   -1, 0};
    vecs[5] = '{5'd4,  6'd2, 64'h414E_0000_0000_0000,  0, 1};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(tx_valid), 0);
    check("rst_data", int'(tx_data), 0);
    rst = 1'b0;

    wr(5'd0, 8'h4B); wr(5'd1, 8'h49); wr(5'd2, 8'h53);
    wr(5'd3, 8'h48); wr(5'd4, 8'h41); wr(5'd5, 8'h4E);
    wr(5'd31, 8'hAA);

    for (int i = 0; i < 6; i++)
      run_stream(vecs[i].base, vecs[i].len, vecs[i].exp, vecs[i].sidx, vecs[i].scyc, 1'b0, 8'h00);

    wr(5'd0, 8'hBB);
    run_stream(5'd31, 6'd2, 64'hAABB_0000_0000_0000, -1, 0, 1'b0, 8'h00);
    wr(5'd0, 8'h4B);

    // abort mid-stream after the second byte handshake
    @(negedge clk);
    start = 1'b1; msg_base = 5'd0; msg_len = 6'd6; tx_ready = 1'b1;
    nb = 0;
    for (int k = 0; k < 50 && nb < 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (tx_valid && tx_ready) nb++;
    end
    check("abort_reached", nb, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; tx_ready = 1'b0;
    check("abort_valid", int'(tx_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    run_stream(5'd0, 6'd6, 64'h4B49_5348_414E_0000, -1, 0, 1'b0, 8'h00);

    wr(5'd8, 8'h11); wr(5'd9, 8'h22);
    run_stream(5'd8, 6'd2, 64'h1122_0000_0000_0000, -1, 0, 1'b1, 8'h99);
    run_stream(5'd8, 6'd2, 64'h9922_0000_0000_0000, -1, 0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
